// File: rtl/simd_pkg.sv
// simd_pkg: shared definitions for the packed SIMD accumulation sequencer.
//   - lane width encodings (W8 / W16 / W32, 2'b11 reserved)
//   - sequencer state enum
//   - saturation byte constants
//   - helpers mapping a lane width to byte-link, lane-MSB and lane-top-byte
package simd_pkg;

  localparam logic [1:0] W8  = 2'b00;
  localparam logic [1:0] W16 = 2'b01;
  localparam logic [1:0] W32 = 2'b10;
  localparam logic [1:0] WRSV = 2'b11;

  localparam int NUM_LANES = 4;

  // Clamp values: the lane's top byte gets 7F/80, lower bytes FF/00.
  localparam logic [7:0] SAT_POS_MSB = 8'h7F;
  localparam logic [7:0] SAT_NEG_MSB = 8'h80;
  localparam logic [7:0] SAT_POS_LSB = 8'hFF;
  localparam logic [7:0] SAT_NEG_LSB = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  // Bit i set: byte i receives the carry out of byte i-1 (same lane).
  function automatic logic [3:0] lane_link(input logic [1:0] width);
    logic [3:0] m;
    case (width)
      W8:      m = 4'b0000;
      W16:     m = 4'b1010;
      W32:     m = 4'b1110;
      default: m = 4'b1110;
    endcase
    return m;
  endfunction

  // Bit i set: byte i holds the sign bit of its lane.
  function automatic logic [3:0] lane_msb(input logic [1:0] width);
    logic [3:0] m;
    case (width)
      W8:      m = 4'b1111;
      W16:     m = 4'b1010;
      W32:     m = 4'b1000;
      default: m = 4'b1000;
    endcase
    return m;
  endfunction

  // Index of the top (sign) byte of the lane containing byte idx.
  function automatic logic [1:0] lane_top(input logic [1:0] width, input logic [1:0] idx);
    logic [1:0] t;
    case (width)
      W8:      t = idx;
      W16:     t = {idx[1], 1'b1};
      W32:     t = 2'd3;
      default: t = 2'd3;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/simd_lane_add.sv
// simd_lane_add: combinational packed signed add of two 32-bit words.
// Carries propagate between bytes only inside a lane; overflow is detected
// per lane at its top byte and, with saturation, the whole lane is clamped
// toward the sign of operand b.
// Ports:
//   i_a     [31:0] accumulator operand
//   i_b     [31:0] incoming operand (its sign picks the clamp direction)
//   i_width [1:0]  lane width encoding
//   i_sat          1 = clamp overflowing lanes, 0 = wrap
//   o_sum   [31:0] packed result
//   o_ovf   [3:0]  overflow flag per lane, placed at the lane's top byte
module simd_lane_add
  import simd_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [1:0]  i_width,
  input  logic        i_sat,
  output logic [31:0] o_sum,
  output logic [3:0]  o_ovf
);

  logic [3:0] w_link;
  logic [3:0] w_msb;

  assign w_link = lane_link(i_width);
  assign w_msb  = lane_msb(i_width);

  // Byte-sliced add with width-gated carry, then per-lane overflow and clamp.
  always_comb begin
    logic       carry;
    logic       cin;
    logic [8:0] tmp;
    logic [7:0] raw [4];
    logic [3:0] ovf;
    logic [1:0] top;

    carry = 1'b0;
    cin   = 1'b0;
    tmp   = 9'd0;
    ovf   = 4'b0000;
    top   = 2'd0;
    o_sum = 32'h0000_0000;
    for (int i = 0; i < NUM_LANES; i++) begin
      raw[i] = 8'h00;
    end

    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_link[i]) begin
        cin = carry;
      end else begin
        cin = 1'b0;
      end
      tmp    = {1'b0, i_a[i*8 +: 8]} + {1'b0, i_b[i*8 +: 8]} + {8'h00, cin};
      raw[i] = tmp[7:0];
      carry  = tmp[8];
    end

    // Signed overflow: operands agree in sign, result disagrees.
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_msb[i]) begin
        ovf[i] = (i_a[i*8+7] == i_b[i*8+7]) && (raw[i][7] != i_a[i*8+7]);
      end else begin
        ovf[i] = 1'b0;
      end
    end

    for (int i = 0; i < NUM_LANES; i++) begin
      top = lane_top(i_width, 2'(i));
      if (i_sat && ovf[top]) begin
        if (i_b[{3'b000, top} * 8 + 7]) begin
          raw[i] = (top == 2'(i)) ? SAT_NEG_MSB : SAT_NEG_LSB;
        end else begin
          raw[i] = (top == 2'(i)) ? SAT_POS_MSB : SAT_POS_LSB;
        end
      end else begin
        raw[i] = raw[i];
      end
      o_sum[i*8 +: 8] = raw[i];
    end

    o_ovf = ovf;
  end

endmodule

// File: rtl/simd_accum_ctrl.sv
// simd_accum_ctrl: sequencer running multi-word packed SIMD accumulation jobs.
// A job latches width/saturate/length on an accepted start, accumulates
// exactly cfg_len operand words, then presents the packed result and sticky
// per-lane overflow flags until the consumer takes them.
// Optional feature macro: SIMD_ACC_ABORT_EN adds an `abort` input that
// returns a running job to IDLE and discards its result.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   abort                 (SIMD_ACC_ABORT_EN only) drop current job
//   start, cfg_width,
//   cfg_saturate, cfg_len job request and configuration
//   in_valid/in_ready/in_data     operand stream
//   out_valid/out_ready/out_data/out_ovf  result channel
//   busy                  state != IDLE
//   cfg_err               one-cycle pulse on start with reserved width
module simd_accum_ctrl
  import simd_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SIMD_ACC_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [1:0]       cfg_width,
  input  logic             cfg_saturate,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [3:0]       out_ovf,
  output logic             busy,
  output logic             cfg_err
);

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_e           r_state;
  logic [1:0]       r_width;
  logic             r_sat;
  logic [LEN_W-1:0] r_cnt;
  logic [31:0]      r_acc;
  logic [3:0]       r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_cfg_err;

  logic [31:0]      w_sum;
  logic [3:0]       w_ovf;
  logic             w_abort;
  logic             w_in_hs;

`ifdef SIMD_ACC_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_in_hs = in_valid & r_in_ready;

  simd_lane_add u_lane_add (
    .i_a     (r_acc),
    .i_b     (in_data),
    .i_width (r_width),
    .i_sat   (r_sat),
    .o_sum   (w_sum),
    .o_ovf   (w_ovf)
  );

  // Job sequencer; every output is a register so no input-to-output comb path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_width     <= W8;
      r_sat       <= 1'b0;
      r_cnt       <= LEN_ZERO;
      r_acc       <= 32'h0000_0000;
      r_ovf       <= 4'b0000;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_cfg_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (cfg_width == WRSV) begin
              r_cfg_err <= 1'b1;
            end else begin
              r_width <= cfg_width;
              r_sat   <= cfg_saturate;
              r_cnt   <= cfg_len;
              r_acc   <= 32'h0000_0000;
              r_ovf   <= 4'b0000;
              r_busy  <= 1'b1;
              if (cfg_len == LEN_ZERO) begin
                r_state     <= ST_DONE;
                r_out_valid <= 1'b1;
              end else begin
                r_state    <= ST_ACCUM;
                r_in_ready <= 1'b1;
              end
            end
          end
        end
        ST_ACCUM: begin
          if (w_abort) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_acc      <= 32'h0000_0000;
            r_ovf      <= 4'b0000;
          end else if (w_in_hs) begin
            r_acc <= w_sum;
            r_ovf <= r_ovf | w_ovf;
            r_cnt <= r_cnt - LEN_ONE;
            if (r_cnt == LEN_ONE) begin
              r_state     <= ST_DONE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (w_abort) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_acc       <= 32'h0000_0000;
            r_ovf       <= 4'b0000;
          end else if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_acc;
  assign out_ovf   = r_ovf;
  assign busy      = r_busy;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_simd_accum_ctrl.sv
// Self-checking bench for simd_accum_ctrl: a table of directed jobs with
// hand-computed results, plus hand-written sequences for reserved width,
// zero length, backpressure, back-to-back start and reset mid-job.
module tb_simd_accum_ctrl;

  logic        clk;
  logic        rst_n;
  logic        abort;
  logic        start;
  logic [1:0]  cfg_width;
  logic        cfg_saturate;
  logic [7:0]  cfg_len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_ovf;
  logic        busy;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  simd_accum_ctrl #(.LEN_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
`ifdef SIMD_ACC_ABORT_EN
    .abort        (abort),
`endif
    .start        (start),
    .cfg_width    (cfg_width),
    .cfg_saturate (cfg_saturate),
    .cfg_len      (cfg_len),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_ovf      (out_ovf),
    .busy         (busy),
    .cfg_err      (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string             name;
    logic [1:0]        w;
    logic              sat;
    int                len;
    logic [3:0][31:0]  d;
    logic [31:0]       exp_d;
    logic [3:0]        exp_o;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string name, input logic [1:0] w, input logic sat, input int len,
                         input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] exp_d, input logic [3:0] exp_o);
    vec_t v;
    v.name = name; v.w = w; v.sat = sat; v.len = len;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = 32'h0;
    v.exp_d = exp_d; v.exp_o = exp_o;
    vecs.push_back(v);
  endtask

  // Runs one job with in_valid held high; checks latency, result and return to IDLE.
  task automatic run_job(input vec_t v);
    @(negedge clk);
    start = 1'b1; cfg_width = v.w; cfg_saturate = v.sat; cfg_len = 8'(v.len);
    @(negedge clk);
    start = 1'b0; cfg_width = 2'b11; cfg_saturate = ~v.sat; cfg_len = 8'd0;
    check({v.name, "_busy"}, {31'd0, busy}, 32'd1);
    check({v.name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < v.len; i++) begin
      in_valid = 1'b1; in_data = v.d[i];
      @(negedge clk);
    end
    in_valid = 1'b0; in_data = 32'hDEAD_BEEF;
    check({v.name, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    check({v.name, "_data"}, out_data, v.exp_d);
    check({v.name, "_ovf"}, {28'd0, out_ovf}, {28'd0, v.exp_o});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({v.name, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
    check({v.name, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    vec_t v;
    logic [31:0] held;

    rst_n = 1'b0; abort = 1'b0; start = 1'b0; cfg_width = 2'b00; cfg_saturate = 1'b0;
    cfg_len = 8'd0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;

    add_vec("w8_sat",     2'b00, 1'b1, 2, 32'h7F7F0101, 32'h01018080, 32'h0, 32'h7F7F8181, 4'b1100);
    add_vec("w16_wrap",   2'b01, 1'b0, 2, 32'h7FFF8000, 32'h00018000, 32'h0, 32'h80000000, 4'b1010);
    add_vec("w32_sat",    2'b10, 1'b1, 2, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 4'b1000);
    add_vec("w8_wrap",    2'b00, 1'b0, 2, 32'h7F800102, 32'h01FF0304, 32'h0, 32'h807F0406, 4'b1100);
    add_vec("w16_satneg", 2'b01, 1'b1, 2, 32'h80000001, 32'hFFFF0002, 32'h0, 32'h80000003, 4'b1000);
    add_vec("w32_wrap",   2'b10, 1'b0, 2, 32'h7FFFFFFF, 32'h00000001, 32'h0, 32'h80000000, 4'b1000);
    add_vec("w32_carry",  2'b10, 1'b0, 2, 32'h000000FF, 32'h00000001, 32'h0, 32'h00000100, 4'b0000);
    add_vec("w8_nocarry", 2'b00, 1'b0, 2, 32'h000000FF, 32'h00000001, 32'h0, 32'h00000000, 4'b0000);
    add_vec("w16_carry",  2'b01, 1'b0, 2, 32'h00FF00FF, 32'h00010001, 32'h0, 32'h01000100, 4'b0000);
    add_vec("w8_satcont", 2'b00, 1'b1, 3, 32'h00000070, 32'h00000070, 32'h00000081, 32'h00000000, 4'b0001);
    add_vec("w8_wrapcont",2'b00, 1'b0, 3, 32'h00000070, 32'h00000070, 32'h00000081, 32'h00000061, 4'b0001);

    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_ovf", {28'd0, out_ovf}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_job(vecs[i]);
    end

    // Reserved width: single cfg_err pulse, FSM stays idle.
    @(negedge clk);
    start = 1'b1; cfg_width = 2'b11; cfg_len = 8'd2;
    @(negedge clk);
    start = 1'b0;
    check("rsv_cfg_err", {31'd0, cfg_err}, 32'd1);
    check("rsv_busy", {31'd0, busy}, 32'd0);
    check("rsv_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("rsv_cfg_err_pulse", {31'd0, cfg_err}, 32'd0);
    check("rsv_busy2", {31'd0, busy}, 32'd0);

    // Backpressure: len 4 with input gaps, out_ready low for 3 cycles.
    @(negedge clk);
    start = 1'b1; cfg_width = 2'b00; cfg_saturate = 1'b0; cfg_len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = {4{8'(i)}};
      @(negedge clk);
      in_valid = 1'b0; in_data = 32'hFFFF_FFFF;
      if (i < 4) begin
        check("bp_not_done", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
      end
    end
    for (int c = 0; c < 3; c++) begin
      start = (c == 1); cfg_width = 2'b10; cfg_len = 8'd0;
      check("bp_valid_held", {31'd0, out_valid}, 32'd1);
      check("bp_data", out_data, 32'h0A0A0A0A);
      check("bp_ovf", {28'd0, out_ovf}, 32'd0);
      @(negedge clk);
    end
    start = 1'b0;
    check("bp_after_start", out_data, 32'h0A0A0A0A);
    check("bp_in_ready_done", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_released", {31'd0, out_valid}, 32'd0);
    // Back-to-back zero-length job right after the handshake.
    start = 1'b1; cfg_width = 2'b10; cfg_saturate = 1'b0; cfg_len = 8'd0;
    @(negedge clk);
    start = 1'b0;
    check("len0_valid", {31'd0, out_valid}, 32'd1);
    check("len0_busy", {31'd0, busy}, 32'd1);
    check("len0_data", out_data, 32'd0);
    check("len0_ovf", {28'd0, out_ovf}, 32'd0);
    check("len0_in_ready", {31'd0, in_ready}, 32'd0);
    held = out_data;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("len0_released", {31'd0, out_valid}, 32'd0);

    // Reset after 2 of 4 words.
    @(negedge clk);
    start = 1'b1; cfg_width = 2'b00; cfg_saturate = 1'b0; cfg_len = 8'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'h11223344;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("mid_partial", out_data, 32'h22446688);
    rst_n = 1'b0;
    #1;
    check("mrst_data", out_data, 32'd0);
    check("mrst_ovf", {28'd0, out_ovf}, 32'd0);
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_no_valid", {31'd0, out_valid}, 32'd0);
    v.name = "post_rst"; v.w = 2'b00; v.sat = 1'b0; v.len = 1;
    v.d = '0; v.d[0] = 32'h01020304; v.exp_d = 32'h01020304; v.exp_o = 4'b0000;
    run_job(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simd_accum_ctrl.md
# simd_accum_ctrl

Sequencer for the packed SIMD saturating adder: runs multi-word accumulation jobs over a streamed operand input, reducing N packed 32-bit words into one packed result at 8-, 16- or 32-bit lane width. Each job latches width/saturate configuration, consumes exactly `cfg_len` words via valid/ready, and presents the result with sticky per-lane overflow flags on a valid/ready output. Sits between the operand buffer and the result writeback, owning the adder's width, saturate and carry-chain control for the duration of a job.

## Interface
- `LEN_W`, 8, width of the job-length field
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  job request; accepted only in IDLE
- `cfg_width`  in  2  lane width: 00 = 4×8, 01 = 2×16, 10 = 1×32, 11 = reserved
- `cfg_saturate`  in  1  1 = clamp overflowing lanes; 0 = wrap
- `cfg_len`  in  LEN_W  words to accumulate (0 allowed)
- `in_valid`  in  1  operand word valid
- `in_ready`  out  1  operand accepted when `in_valid & in_ready`
- `in_data`  in  32  packed signed operand
- `out_valid`  out  1  result valid
- `out_ready`  in  1  result consumed when `out_valid & out_ready`
- `out_data`  out  32  packed accumulated result
- `out_ovf`  out  4  sticky overflow flags, one per byte lane position
- `busy`  out  1  state ≠ IDLE
- `cfg_err`  out  1  one-cycle pulse: `start` in IDLE with `cfg_width` = 11

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: `start` with legal width latches width, saturate and length; clears accumulator and flags. Next state is ACCUM, or DONE if `cfg_len` = 0. Width 11 produces a `cfg_err` pulse, and the FSM stays in IDLE.
- ACCUM: `in_ready` = 1. Each handshake sets acc ← lane-wise signed add(acc, `in_data`), with carry chained inside each lane only. The beat that exhausts the count moves to DONE.
- DONE: `out_valid` = 1. `out_data`/`out_ovf` hold stable until `out_ready`; the handshake returns to IDLE.
- `start` outside IDLE is ignored. Configuration inputs are sampled only on accepted `start`.
- Overflow is signed two's complement per lane. With saturate, the lane clamps to 0x7F…/0x80… by the sign of the operand, and later beats continue from the clamped value. Without saturate, the lane wraps.
- Flag position is the lane MSB byte: 8-bit → bits 3..0; 16-bit → bits 3, 1; 32-bit → bit 3. Unused flag bits are 0. Flags are ORed across beats.

## Timing
- Reset value of every output: 0. State is IDLE and the accumulator is 0.
- `busy` rises the cycle after `start` is accepted.
- Result latency: `out_valid` is asserted the cycle after the final input handshake. For `cfg_len` = 0, it is asserted the cycle after `start`.
- Throughput: one word per cycle while `in_valid` is high. No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.
- Back-to-back: a `start` in the cycle after the output handshake is accepted (IDLE reached).
- Reset asserted mid-job: the job is dropped immediately; any partial result is never presented.

## Configuration
- `SIMD_ACC_ABORT_EN` defined: adds port `abort` in 1. In ACCUM or DONE, `abort` forces IDLE on the next edge and drops `out_valid` without a handshake. Accumulator and flags are cleared. `abort` has priority over input and output handshakes in the same cycle.
- Undefined: no `abort` port; jobs run to completion or reset.

## Structure
- Package `simd_pkg`: width encodings (W8 = 2'b00, W16 = 2'b01, W32 = 2'b10), lane count 4, FSM state enum, saturation constants.
- Sub-module `simd_lane_add`: combinational packed add with width-gated inter-byte carry, saturation and per-lane overflow. Instantiated once; the controller owns all sequencing and registers.

## Test plan
- W8, sat = 1, len = 2, words 0x7F7F0101, 0x01018080 → `out_data` 0x7F7F8181, `out_ovf` 4'b1100.
- W16, sat = 0, len = 2, words 0x7FFF8000, 0x00018000 → `out_data` 0x80000000, `out_ovf` 4'b1010.
- W32, sat = 1, len = 2, words 0x80000000, 0xFFFFFFFF → `out_data` 0x80000000, `out_ovf` 4'b1000. Width 11 `start` → `cfg_err` pulse, `busy` stays 0.
- len = 0 → `out_valid` the cycle after `start`, `out_data` 0, `out_ovf` 0.
- Backpressure: len = 4 with `in_valid` gaps, `out_ready` held low 3 cycles → outputs stable, sum correct, and `start` during DONE ignored.
- Reset mid-ACCUM after 2 of 4 words → all outputs 0. Next job (W8, len = 1, 0x01020304) returns 0x01020304, `out_ovf` 0.
